mult_div_unit: RTL and testbench

- Sequential signed multiply/divide unit for the multicycle MIPS datapath.
- It is the responder to the control unit's MultCtrl/DivCtrl start pulses.
- Operands come from the A/B operand registers.
- It produces 64-bit results that the datapath loads into the HI and LOW registers when HiLow is asserted.
- Multiply is radix-2 Booth. Divide is restoring, with sign fix-up.

---
 rtl/mult_div_pkg.sv | 16 +
 rtl/mult_div_unit_div_step.sv | 23 ++
 rtl/mult_div_unit.sv | 141 ++++++++++++++
 tb/tb_mult_div_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// rtl/mult_div_pkg.sv - shared types and constants for the multiply/divide unit
package mult_div_pkg;

    localparam int MD_WIDTH   = 32;
    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = $clog2(ITER_COUNT);

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        FIX,
        DONE
    } mdState_t;

endpackage

// File: rtl/mult_div_unit_div_step.sv
// rtl/mult_div_unit_div_step.sv - one combinational restoring-division step on magnitudes
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic             dividendBit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remOut,
    output logic             quoBit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // remIn < divisor, so the trial difference always fits in WIDTH+1 signed bits
    always_comb begin
        shifted = {remIn, dividendBit};
        diff    = shifted - {1'b0, divisor};
        quoBit  = ~diff[WIDTH];
        remOut  = quoBit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - sequential signed Booth multiply / restoring divide with HI/LO results
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_COUNT - 1);

    mdState_t           state, nextState;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH:0]   acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   divisor, quo, rem;
    logic               dividendNeg, signsDiffer;
    logic [WIDTH-1:0]   hiReg, loReg;
    logic               divZeroReg;

    logic               canAccept, bZero, lastIter;
    logic               acceptMult, acceptDiv, acceptDivZero;
    logic [WIDTH:0]     boothSum;
    logic [2*WIDTH:0]   boothNext;
    logic [WIDTH-1:0]   remNext;
    logic               quoBit;
    logic [WIDTH-1:0]   aMag, bMag;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .remIn       (rem),
        .dividendBit (quo[WIDTH-1]),
        .divisor     (divisor),
        .remOut      (remNext),
        .quoBit      (quoBit)
    );

    always_comb begin
        canAccept     = (state == IDLE) || (state == DONE);
        bZero         = (b == '0);
        lastIter      = (count == LAST_ITER);
        acceptMult    = canAccept && mult_start;
        acceptDiv     = canAccept && !mult_start && div_start && !bZero;
        acceptDivZero = canAccept && !mult_start && div_start && bZero;
        aMag          = a[WIDTH-1] ? -a : a;
        bMag          = b[WIDTH-1] ? -b : b;

        nextState = state;
        case (state)
            IDLE, DONE: begin
                if (acceptMult)         nextState = MULT;
                else if (acceptDiv)     nextState = DIV;
                else if (acceptDivZero) nextState = DONE;
                else                    nextState = IDLE;
            end
            MULT:    if (lastIter) nextState = DONE;
            DIV:     if (lastIter) nextState = FIX;
            FIX:     nextState = DONE;
            default: nextState = IDLE;
        endcase
    end

    // Booth add/sub is one bit wider so subtracting the most negative multiplicand cannot overflow
    always_comb begin
        case (acc[1:0])
            2'b01:   boothSum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]} + {mcand[WIDTH-1], mcand};
            2'b10:   boothSum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]} - {mcand[WIDTH-1], mcand};
            default: boothSum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
        endcase
        boothNext = {boothSum, acc[WIDTH:1]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count       <= '0;
            acc         <= '0;
            mcand       <= '0;
            divisor     <= '0;
            quo         <= '0;
            rem         <= '0;
            dividendNeg <= 1'b0;
            signsDiffer <= 1'b0;
            hiReg       <= '0;
            loReg       <= '0;
            divZeroReg  <= 1'b0;
        end else begin
            divZeroReg <= acceptDivZero;
            if (acceptMult) begin
                acc   <= {{WIDTH{1'b0}}, b, 1'b0};
                mcand <= a;
                count <= '0;
            end else if (acceptDiv) begin
                quo         <= aMag;
                divisor     <= bMag;
                rem         <= '0;
                dividendNeg <= a[WIDTH-1];
                signsDiffer <= a[WIDTH-1] ^ b[WIDTH-1];
                count       <= '0;
            end else begin
                case (state)
                    MULT: begin
                        acc   <= boothNext;
                        count <= count + CNT_W'(1);
                        if (lastIter) {hiReg, loReg} <= boothNext[2*WIDTH:1];
                    end
                    DIV: begin
                        rem   <= remNext;
                        quo   <= {quo[WIDTH-2:0], quoBit};
                        count <= count + CNT_W'(1);
                    end
                    FIX: begin
                        hiReg <= dividendNeg ? -rem : rem;
                        loReg <= signsDiffer ? -quo : quo;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy     = (state == MULT) || (state == DIV) || (state == FIX);
    assign done     = (state == DONE);
    assign div_zero = divZeroReg;
    assign hi       = hiReg;
    assign lo       = loReg;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit against an arithmetic reference
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mult_start = 1'b0;
    logic        div_start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero;

    int          nCompared = 0;
    int          nMismatched = 0;
    logic [31:0] expHi = '0;
    logic [31:0] expLo = '0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .mult_start (mult_start),
        .div_start  (div_start),
        .a          (a),
        .b          (b),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] refMult(input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        sx = $signed(x);
        sy = $signed(y);
        return 64'(sx * sy);
    endfunction

    // 64-bit arithmetic sidesteps the 32-bit overflow case; division truncates toward zero
    function automatic logic [63:0] refDiv(input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        sx = $signed(x);
        sy = $signed(y);
        q  = sx / sy;
        r  = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    // Drives a request at the current negedge and follows it to the done pulse.
    task automatic runOp(input bit doMult, input bit doDiv, input logic [31:0] opA,
                         input logic [31:0] opB, input int pokeAt, input string tag);
        int          edges, busyCnt, expLat;
        bit          overlap, expDz;
        logic [63:0] r;
        mult_start = doMult;
        div_start  = doDiv;
        a = opA;
        b = opB;
        @(negedge clk);
        mult_start = 1'b0;
        div_start  = 1'b0;
        a = $urandom;
        b = $urandom;
        edges = 0;
        busyCnt = 0;
        overlap = 1'b0;
        while (done !== 1'b1 && edges < 100) begin
            if (busy === 1'b1) busyCnt++;
            mult_start = (edges == pokeAt);
            if (edges == pokeAt) begin
                a = $urandom;
                b = $urandom;
            end
            @(negedge clk);
            edges++;
            mult_start = 1'b0;
            if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
        end
        expDz = 1'b0;
        if (doMult) begin
            r = refMult(opA, opB);
            expHi = r[63:32];
            expLo = r[31:0];
            expLat = 32;
        end else if (opB == 32'h0) begin
            expDz = 1'b1;
            expLat = 0;
        end else begin
            r = refDiv(opA, opB);
            expHi = r[63:32];
            expLo = r[31:0];
            expLat = 33;
        end
        checkVal({tag, ".latency"}, 64'(edges), 64'(expLat));
        checkVal({tag, ".busyCycles"}, 64'(busyCnt), 64'(expLat));
        checkVal({tag, ".done"}, 64'(done), 64'(1));
        checkVal({tag, ".busyDoneOverlap"}, 64'(overlap), 64'(0));
        checkVal({tag, ".hi"}, 64'(hi), 64'(expHi));
        checkVal({tag, ".lo"}, 64'(lo), 64'(expLo));
        checkVal({tag, ".divZero"}, 64'(div_zero), 64'(expDz));
    endtask

    function automatic logic [31:0] pickOperand();
        int sel;
        sel = $urandom_range(0, 5);
        case (sel)
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 20)) - 32'd10;
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        checkVal("reset.hi", 64'(hi), 64'(0));
        checkVal("reset.lo", 64'(lo), 64'(0));
        checkVal("reset.busy", 64'(busy), 64'(0));
        checkVal("reset.done", 64'(done), 64'(0));
        checkVal("reset.divZero", 64'(div_zero), 64'(0));
        reset = 1'b1;
        @(negedge clk);

        runOp(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, -1, "mul7xm3");
        @(negedge clk);
        checkVal("idle.done", 64'(done), 64'(0));
        runOp(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, -1, "mulMinSq");
        @(negedge clk);
        runOp(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, -1, "divM7by2");
        @(negedge clk);
        runOp(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, "divOverflow");
        @(negedge clk);
        runOp(1'b1, 1'b0, 32'd6, 32'h2AAA_AAAB, -1, "mulHi1Lo2");
        runOp(1'b0, 1'b1, 32'd5, 32'd0, -1, "divByZero");
        @(negedge clk);
        checkVal("afterDz.divZero", 64'(div_zero), 64'(0));
        runOp(1'b1, 1'b1, 32'd100, 32'hFFFF_FFF6, -1, "bothStarts");
        @(negedge clk);
        runOp(1'b1, 1'b0, 32'h1234_5678, 32'h0000_9ABC, 5, "pokeWhileBusy");
        @(negedge clk);
        runOp(1'b0, 1'b1, 32'd1000, 32'hFFFF_FFF9, 7, "pokeWhileDiv");
        runOp(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_0003, -1, "backToBack");

        // abandon a divide partway through with an asynchronous reset
        @(negedge clk);
        div_start = 1'b1;
        a = 32'hFFFF_0001;
        b = 32'd13;
        @(negedge clk);
        div_start = 1'b0;
        repeat (10) @(negedge clk);
        checkVal("midDiv.busy", 64'(busy), 64'(1));
        #2 reset = 1'b0;
        #1;
        checkVal("asyncReset.hi", 64'(hi), 64'(0));
        checkVal("asyncReset.lo", 64'(lo), 64'(0));
        checkVal("asyncReset.busy", 64'(busy), 64'(0));
        checkVal("asyncReset.done", 64'(done), 64'(0));
        checkVal("asyncReset.divZero", 64'(div_zero), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        expHi = '0;
        expLo = '0;
        @(negedge clk);
        runOp(1'b1, 1'b0, 32'd3, 32'd4, -1, "mul3x4");

        for (int i = 0; i < 30; i++) begin
            int kind;
            logic [31:0] opA, opB;
            kind = $urandom_range(0, 3);
            opA = pickOperand();
            opB = pickOperand();
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            case (kind)
                0:       runOp(1'b1, 1'b0, opA, opB, -1, "rndMul");
                1:       runOp(1'b0, 1'b1, opA, (opB == 32'h0) ? 32'd1 : opB, -1, "rndDiv");
                2:       runOp(1'b0, 1'b1, opA, 32'h0, -1, "rndDivZero");
                default: runOp(1'b1, 1'b1, opA, opB, -1, "rndBoth");
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
